// File: rtl/spi_pkg.sv
// Shared SPI widths, command/response records and driver state encoding.
// Also supplies the saturating counter helper used when SPI_DRV_STATS_EN is defined.
package spi_pkg;

    localparam int DWIDTH = 8;
    localparam int AWIDTH = 8;
    localparam int CMD_W  = DWIDTH + AWIDTH + 5;
    localparam int RSP_W  = 2 + AWIDTH + DWIDTH;

    typedef struct packed {
        logic [1:0]        ss;
        logic [DWIDTH-1:0] data;
        logic [AWIDTH-1:0] addr;
        logic [1:0]        size;
        logic              write;
    } spi_cmd_t;

    typedef struct packed {
        logic [1:0]        ss;
        logic [AWIDTH-1:0] addr;
        logic [DWIDTH-1:0] data;
    } spi_rsp_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } drv_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data and synchronous reset.
// Full/empty come from one extra pointer bit; DEPTH must be a power of two.
module spi_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // A push into a full FIFO is allowed only when the head leaves in the same cycle.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/spi_cmd_driver.sv
// Command front-end for the SPI master: command FIFO, driver_* handshake, response FIFO.
// Optional SPI_DRV_STATS_EN adds saturating retired-write/read counters.
module spi_cmd_driver
    import spi_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CMD_W-1:0]  cmd_data,
    input  logic [1:0]        cfg_mode,
    input  logic              cfg_we,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWIDTH-1:0] rsp_data,
    output logic [AWIDTH-1:0] rsp_addr,
    output logic [1:0]        rsp_ss,
    output logic              busy,
    output logic              master_en,
    output logic [CMD_W-1:0]  driver_data,
    output logic [1:0]        driver_cfg,
    input  logic              driver_read,
    input  logic [DWIDTH-1:0] spi_slv_data,
`ifdef SPI_DRV_STATS_EN
    output logic [15:0]       stat_wr_cnt,
    output logic [15:0]       stat_rd_cnt,
`endif
    output drv_state_t        o_dbg_state
);

    // Handshake: a command moves to the master on the cycle driver_read and
    // master_en are both high (ev); master_en drops combinationally to park it.
    drv_state_t r_state;
    spi_cmd_t   r_cmd_q;
    logic [1:0] r_cfg;

    spi_cmd_t   w_cmd_head;
    logic       w_cmd_full;
    logic       w_cmd_empty;
    logic       w_cmd_push;
    spi_rsp_t   w_rsp_wr;
    spi_rsp_t   w_rsp_head;
    logic       w_rsp_full;
    logic       w_rsp_empty;
    logic       w_rsp_push;
    logic       w_inflight_vld;
    logic       w_inflight_rd;
    logic       w_stall;
    logic       w_ev;
    logic       w_final_retire;

    assign w_inflight_vld = (r_state == ACTIVE);
    assign w_inflight_rd  = w_inflight_vld & ~r_cmd_q.write;

    assign w_stall   = driver_read & (w_cmd_empty | (w_inflight_rd & w_rsp_full));
    assign w_ev      = driver_read & ~w_stall;
    assign master_en = ~w_stall;

    // A read result is captured whenever the master reports back and space exists,
    // including the last command retiring into an empty command FIFO.
    assign w_rsp_push     = driver_read & w_inflight_rd & ~w_rsp_full;
    assign w_final_retire = driver_read & w_cmd_empty & w_inflight_vld &
                            (r_cmd_q.write | ~w_rsp_full);

    assign w_cmd_push = cmd_valid & ~w_cmd_full;
    assign w_rsp_wr   = '{ss: r_cmd_q.ss, addr: r_cmd_q.addr, data: spi_slv_data};

    spi_sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (w_cmd_push),
        .wr_data (cmd_data),
        .pop     (w_ev),
        .rd_data (w_cmd_head),
        .full    (w_cmd_full),
        .empty   (w_cmd_empty)
    );

    spi_sync_fifo #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (w_rsp_push),
        .wr_data (w_rsp_wr),
        .pop     (rsp_ready),
        .rd_data (w_rsp_head),
        .full    (w_rsp_full),
        .empty   (w_rsp_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cmd_q <= '0;
        end else if (w_ev) begin
            r_state <= ACTIVE;
            r_cmd_q <= w_cmd_head;
        end else if (w_final_retire) begin
            r_state <= IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg <= 2'b00;
        end else if (cfg_we && !busy) begin
            r_cfg <= cfg_mode;
        end
    end

`ifdef SPI_DRV_STATS_EN
    logic       w_retire;
    logic [15:0] r_stat_wr;
    logic [15:0] r_stat_rd;

    assign w_retire = (w_ev & w_inflight_vld) | w_final_retire;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_wr <= '0;
            r_stat_rd <= '0;
        end else if (w_retire) begin
            if (r_cmd_q.write) r_stat_wr <= sat_inc16(r_stat_wr);
            else               r_stat_rd <= sat_inc16(r_stat_rd);
        end
    end

    assign stat_wr_cnt = r_stat_wr;
    assign stat_rd_cnt = r_stat_rd;
`endif

    assign cmd_ready   = ~w_cmd_full;
    assign busy        = w_inflight_vld | ~w_cmd_empty;
    assign driver_data = r_cmd_q;
    assign driver_cfg  = r_cfg;
    assign rsp_valid   = ~w_rsp_empty;
    assign rsp_data    = w_rsp_head.data;
    assign rsp_addr    = w_rsp_head.addr;
    assign rsp_ss      = w_rsp_head.ss;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_spi_cmd_driver.sv
// Bench for spi_cmd_driver: the bench plays the SPI master on the driver_* handshake.
// Table-driven single-command vectors plus hand-written FIFO-full, backpressure and reset sequences.
module tb_spi_cmd_driver;
    import spi_pkg::*;

    localparam int CMD_DEPTH = 4;
    localparam int RSP_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [CMD_W-1:0]  cmd_data = '0;
    logic [1:0]        cfg_mode = 2'b00;
    logic              cfg_we = 1'b0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DWIDTH-1:0] rsp_data;
    logic [AWIDTH-1:0] rsp_addr;
    logic [1:0]        rsp_ss;
    logic              busy;
    logic              master_en;
    logic [CMD_W-1:0]  driver_data;
    logic [1:0]        driver_cfg;
    logic              driver_read = 1'b0;
    logic [DWIDTH-1:0] spi_slv_data = '0;
    drv_state_t        dbg_state;
`ifdef SPI_DRV_STATS_EN
    logic [15:0]       stat_wr_cnt;
    logic [15:0]       stat_rd_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [CMD_W-1:0] exp_q[$];
    logic [RSP_W-1:0] rsp_q[$];

    typedef struct {
        logic [1:0] ss;
        logic [7:0] data;
        logic [7:0] addr;
        logic [1:0] size;
        logic       write;
        logic [7:0] slv;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic [7:0] exp_addr;
        logic [1:0] exp_ss;
    } vec_t;

    vec_t vecs[6];

    spi_cmd_driver #(.CMD_DEPTH(CMD_DEPTH), .RSP_DEPTH(RSP_DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_data     (cmd_data),
        .cfg_mode     (cfg_mode),
        .cfg_we       (cfg_we),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_addr     (rsp_addr),
        .rsp_ss       (rsp_ss),
        .busy         (busy),
        .master_en    (master_en),
        .driver_data  (driver_data),
        .driver_cfg   (driver_cfg),
        .driver_read  (driver_read),
        .spi_slv_data (spi_slv_data),
`ifdef SPI_DRV_STATS_EN
        .stat_wr_cnt  (stat_wr_cnt),
        .stat_rd_cnt  (stat_rd_cnt),
`endif
        .o_dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CMD_W-1:0] mk_cmd(input logic [1:0] ss, input logic [7:0] data,
                                                 input logic [7:0] addr, input logic [1:0] size,
                                                 input logic write);
        spi_cmd_t c;
        c = '{ss: ss, data: data, addr: addr, size: size, write: write};
        return c;
    endfunction

    task automatic push_cmd(input logic [CMD_W-1:0] c);
        cmd_valid = 1'b1;
        cmd_data  = c;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        logic [CMD_W-1:0] c;
        logic [RSP_W-1:0] r;
        int waited;

        vecs[0] = '{ss: 2'd1, data: 8'hA5, addr: 8'h03, size: 2'd0, write: 1'b1, slv: 8'h00,
                    exp_valid: 1'b0, exp_data: 8'h00, exp_addr: 8'h00, exp_ss: 2'd0};
        vecs[1] = '{ss: 2'd2, data: 8'h00, addr: 8'h07, size: 2'd0, write: 1'b0, slv: 8'h3C,
                    exp_valid: 1'b1, exp_data: 8'h3C, exp_addr: 8'h07, exp_ss: 2'd2};
        vecs[2] = '{ss: 2'd3, data: 8'h5A, addr: 8'hFF, size: 2'd1, write: 1'b0, slv: 8'h00,
                    exp_valid: 1'b1, exp_data: 8'h00, exp_addr: 8'hFF, exp_ss: 2'd3};
        vecs[3] = '{ss: 2'd0, data: 8'hFF, addr: 8'h00, size: 2'd2, write: 1'b1, slv: 8'hAA,
                    exp_valid: 1'b0, exp_data: 8'h00, exp_addr: 8'h00, exp_ss: 2'd0};
        vecs[4] = '{ss: 2'd0, data: 8'h00, addr: 8'h80, size: 2'd1, write: 1'b0, slv: 8'hFF,
                    exp_valid: 1'b1, exp_data: 8'hFF, exp_addr: 8'h80, exp_ss: 2'd0};
        vecs[5] = '{ss: 2'd1, data: 8'h12, addr: 8'h34, size: 2'd3, write: 1'b1, slv: 8'h55,
                    exp_valid: 1'b0, exp_data: 8'h00, exp_addr: 8'h00, exp_ss: 2'd0};

        // Reset values
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_master_en", master_en, 1);
        check("rst_driver_data", driver_data, 0);
        check("rst_driver_cfg", driver_cfg, 0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));

        // Master requests with nothing queued: parked
        driver_read = 1'b1;
        #1;
        check("idle_master_en", master_en, 0);
        repeat (3) tick();
        check("idle_busy", busy, 0);
        check("idle_rsp_valid", rsp_valid, 0);
        check("idle_state", 32'(dbg_state), 32'(IDLE));

        // Single-command vectors, master request held high while idle
        for (int i = 0; i < 6; i++) begin
            c = mk_cmd(vecs[i].ss, vecs[i].data, vecs[i].addr, vecs[i].size, vecs[i].write);
            cmd_valid = 1'b1;
            cmd_data  = c;
            #1;
            check($sformatf("v%0d_cmd_ready", i), cmd_ready, 1);
            tick();
            cmd_valid = 1'b0;
            #1;
            check($sformatf("v%0d_en_pop", i), master_en, 1);
            check($sformatf("v%0d_busy_q", i), busy, 1);
            tick();
            driver_read = 1'b0;
            #1;
            check($sformatf("v%0d_driver_data", i), driver_data, c);
            check($sformatf("v%0d_state_act", i), 32'(dbg_state), 32'(ACTIVE));
            check($sformatf("v%0d_busy_fly", i), busy, 1);
            repeat (3) tick();
            spi_slv_data = vecs[i].slv;
            driver_read  = 1'b1;
            #1;
            check($sformatf("v%0d_en_stall", i), master_en, 0);
            tick();
            check($sformatf("v%0d_busy_done", i), busy, 0);
            check($sformatf("v%0d_rsp_valid", i), rsp_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) begin
                check($sformatf("v%0d_rsp_data", i), rsp_data, vecs[i].exp_data);
                check($sformatf("v%0d_rsp_addr", i), rsp_addr, vecs[i].exp_addr);
                check($sformatf("v%0d_rsp_ss", i), rsp_ss, vecs[i].exp_ss);
                rsp_ready = 1'b1;
                tick();
                rsp_ready = 1'b0;
                #1;
                check($sformatf("v%0d_rsp_drained", i), rsp_valid, 0);
            end
        end

        // Mode load while idle
        cfg_mode = 2'b10;
        cfg_we   = 1'b1;
        tick();
        cfg_we = 1'b0;
        #1;
        check("cfg_idle_load", driver_cfg, 2'b10);

        // Fill the command FIFO with CMD_DEPTH+1 writes, master not requesting
        driver_read = 1'b0;
        for (int i = 0; i < CMD_DEPTH + 1; i++) begin
            c = mk_cmd(2'(i), 8'(8'h10 + i), 8'(i), 2'd0, 1'b1);
            cmd_valid = 1'b1;
            cmd_data  = c;
            #1;
            check($sformatf("fill_ready%0d", i), cmd_ready, (i < CMD_DEPTH) ? 1 : 0);
            if (i < CMD_DEPTH) exp_q.push_back(c);
            tick();
        end
        cmd_valid = 1'b0;

        // Mode load while busy is ignored
        cfg_mode = 2'b01;
        cfg_we   = 1'b1;
        tick();
        cfg_we = 1'b0;
        #1;
        check("cfg_busy_ignored", driver_cfg, 2'b10);

        for (int k = 0; k < CMD_DEPTH; k++) begin
            driver_read = 1'b1;
            #1;
            check($sformatf("fill_en%0d", k), master_en, 1);
            tick();
            driver_read = 1'b0;
            #1;
            check($sformatf("fill_order%0d", k), driver_data, exp_q.pop_front());
            tick();
        end
        driver_read = 1'b1;
        #1;
        check("fill_no_extra", master_en, 0);
        tick();
        check("fill_busy_done", busy, 0);
        check("fill_state_idle", 32'(dbg_state), 32'(IDLE));

        // RSP_DEPTH+1 reads with the host not popping responses
        driver_read = 1'b0;
        for (int k = 0; k < RSP_DEPTH + 1; k++) begin
            push_cmd(mk_cmd(2'(k), 8'h00, 8'(8'h20 + k), 2'd0, 1'b0));
            spi_slv_data = 8'(8'h40 + k - 1);
            driver_read  = 1'b1;
            #1;
            check($sformatf("bp_en%0d", k), master_en, 1);
            tick();
            driver_read = 1'b0;
            r = {2'(k), 8'(8'h20 + k), 8'(8'h40 + k)};
            rsp_q.push_back(r);
        end
        push_cmd(mk_cmd(2'd3, 8'hC3, 8'h99, 2'd0, 1'b1));
        spi_slv_data = 8'h44;
        driver_read  = 1'b1;
        #1;
        check("bp_stall", master_en, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("bp_hold_en%0d", k), master_en, 0);
            check($sformatf("bp_hold_busy%0d", k), busy, 1);
        end
        r = rsp_q.pop_front();
        check("bp_first_rsp", {rsp_ss, rsp_addr, rsp_data}, r);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        waited = 0;
        while (!master_en && waited < 8) begin
            tick();
            waited++;
        end
        check("bp_resume", master_en, 1);
        tick();
        driver_read = 1'b0;
        #1;
        check("bp_next_cmd", driver_data, mk_cmd(2'd3, 8'hC3, 8'h99, 2'd0, 1'b1));
        for (int k = 0; k < RSP_DEPTH; k++) begin
            check($sformatf("bp_rsp_valid%0d", k), rsp_valid, 1);
            r = rsp_q.pop_front();
            check($sformatf("bp_rsp%0d", k), {rsp_ss, rsp_addr, rsp_data}, r);
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
        end
        #1;
        check("bp_rsp_empty", rsp_valid, 0);
        driver_read = 1'b1;
        tick();
        check("bp_busy_done", busy, 0);

        // Reset with a response queued, a read in flight and a command waiting
        driver_read = 1'b0;
        push_cmd(mk_cmd(2'd1, 8'h00, 8'h50, 2'd0, 1'b0));
        driver_read = 1'b1;
        tick();
        driver_read = 1'b0;
        push_cmd(mk_cmd(2'd2, 8'h00, 8'h51, 2'd0, 1'b0));
        spi_slv_data = 8'h77;
        driver_read  = 1'b1;
        tick();
        driver_read = 1'b0;
        push_cmd(mk_cmd(2'd0, 8'h11, 8'h52, 2'd0, 1'b1));
        #1;
        check("pre_rst_rsp_valid", rsp_valid, 1);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_cmd_ready", cmd_ready, 1);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_driver_data", driver_data, 0);
        check("mid_rst_driver_cfg", driver_cfg, 0);
        check("mid_rst_master_en", master_en, 1);
        check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
`ifdef SPI_DRV_STATS_EN
        check("mid_rst_stat_wr", stat_wr_cnt, 0);
        check("mid_rst_stat_rd", stat_rd_cnt, 0);
`endif
        spi_slv_data = 8'h99;
        driver_read  = 1'b1;
        #1;
        check("post_rst_stall", master_en, 0);
        tick();
        check("post_rst_no_rsp", rsp_valid, 0);
        check("post_rst_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
